// File: rtl/ltc2333_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ltc2333_pkg : shared types and word layout for ltc2333_readout     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ltc2333_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CNV_HI    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_DRAIN     = 3'd4
   } state_e;

   // Captured word layout: {result, channel, span}, span in the LSBs.
   localparam int RESULT_BITS = 18;
   localparam int CHAN_BITS   = 3;
   localparam int SPAN_BITS   = 3;
   localparam int CHAN_LSB    = SPAN_BITS;
   localparam int RESULT_LSB  = CHAN_LSB + CHAN_BITS;
   localparam int WORD_BITS   = RESULT_LSB + RESULT_BITS;

   localparam int DRAIN_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/sync2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync2ff : two-flop synchronizer for a single asynchronous input    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/ltc2333_readout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ltc2333_readout : conversion sequencer and serial readout for an   |
// | LTC2333-style SAR ADC with a valid/ready word output.  Rev 1.0     |
// +--------------------------------------------------------------------+
module ltc2333_readout
   import ltc2333_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int N_WORDS    = 8,
   parameter int T_CNV_HI   = 4,
   parameter int T_CONV_MAX = 60
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 start,
   input  logic [WORD_BITS-1:0] span_cfg,
   output logic                 cnv,
   input  logic                 adc_busy,
   output logic                 scki,
   output logic                 sdi,
   input  logic                 scko,
   input  logic                 sdo,
   output logic [WORD_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 active,
   output logic                 timeout,
   output logic                 overflow
);

   localparam int TOGGLES = 2 * WORD_BITS * N_WORDS;

   state_e               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [7:0]           div_q, div_d;
   logic [8:0]           tog_q, tog_d;
   logic                 scki_q, scki_d;
   logic [WORD_BITS-1:0] sdi_sr_q, sdi_sr_d;
   logic [WORD_BITS-2:0] shreg_q, shreg_d;
   logic [4:0]           bit_q, bit_d;
   logic [2:0]           word_q, word_d;
   logic                 busy_prev_q, busy_prev_d;
   logic                 scko_prev_q, scko_prev_d;
   logic [WORD_BITS-1:0] m_data_q, m_data_d;
   logic                 m_valid_q, m_valid_d;
   logic                 timeout_q, timeout_d;
   logic                 overflow_q, overflow_d;

   logic busy_s, scko_s, sdo_s;
   logic busy_fall, scko_fall, scko_edge;
   logic word_done;

   sync2ff u_sync_busy (.clk(aclk), .rst_n(aresetn), .d(adc_busy), .q(busy_s));
   sync2ff u_sync_scko (.clk(aclk), .rst_n(aresetn), .d(scko),     .q(scko_s));
   sync2ff u_sync_sdo  (.clk(aclk), .rst_n(aresetn), .d(sdo),      .q(sdo_s));

   assign busy_fall = busy_prev_q & ~busy_s;
   assign scko_fall = scko_prev_q & ~scko_s;
   assign scko_edge = scko_prev_q ^ scko_s;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      tog_d       = tog_q;
      scki_d      = scki_q;
      sdi_sr_d    = sdi_sr_q;
      shreg_d     = shreg_q;
      bit_d       = bit_q;
      word_d      = word_q;
      busy_prev_d = busy_s;
      scko_prev_d = scko_s;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      timeout_d   = timeout_q;
      overflow_d  = overflow_q;
      word_done   = 1'b0;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_CNV_HI;
               cnt_d    = '0;
               sdi_sr_d = span_cfg;
            end
         end

         ST_CNV_HI: begin
            if (cnt_q == 16'(T_CNV_HI - 1)) begin
               state_d = ST_WAIT_BUSY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         ST_WAIT_BUSY: begin
            if (busy_fall) begin
               state_d = ST_SHIFT;
               div_d   = '0;
               tog_d   = '0;
               bit_d   = '0;
               word_d  = '0;
            end else if (cnt_q == 16'(T_CONV_MAX)) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
               sdi_sr_d  = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         ST_SHIFT: begin
            if (tog_q != 9'(TOGGLES)) begin
               if (div_q == 8'(CLK_DIV - 1)) begin
                  div_d  = '0;
                  tog_d  = tog_q + 9'd1;
                  scki_d = ~scki_q;
                  // next config bit appears on the falling edge just produced
                  if (scki_q) begin
                     sdi_sr_d = {sdi_sr_q[WORD_BITS-2:0], 1'b0};
                  end
               end else begin
                  div_d = div_q + 8'd1;
               end
            end

            if (scko_fall) begin
               shreg_d = {shreg_q[WORD_BITS-3:0], sdo_s};
               if (bit_q == 5'(WORD_BITS - 1)) begin
                  bit_d     = '0;
                  word_done = 1'b1;
                  if (word_q == 3'(N_WORDS - 1)) begin
                     word_d  = '0;
                     state_d = ST_DRAIN;
                     cnt_d   = '0;
                  end else begin
                     word_d = word_q + 3'd1;
                  end
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end
         end

         ST_DRAIN: begin
            if (scko_edge) begin
               cnt_d = '0;
            end else if (cnt_q == 16'(DRAIN_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // a completed word needs the output register free or emptying this cycle
      if (word_done) begin
         if (!m_valid_q || m_ready) begin
            m_data_d  = {shreg_q, sdo_s};
            m_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         div_q       <= '0;
         tog_q       <= '0;
         scki_q      <= 1'b0;
         sdi_sr_q    <= '0;
         shreg_q     <= '0;
         bit_q       <= '0;
         word_q      <= '0;
         busy_prev_q <= 1'b0;
         scko_prev_q <= 1'b0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         timeout_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         tog_q       <= tog_d;
         scki_q      <= scki_d;
         sdi_sr_q    <= sdi_sr_d;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         word_q      <= word_d;
         busy_prev_q <= busy_prev_d;
         scko_prev_q <= scko_prev_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         timeout_q   <= timeout_d;
         overflow_q  <= overflow_d;
      end
   end

   assign cnv      = (state_q == ST_CNV_HI);
   assign active   = (state_q != ST_IDLE);
   assign scki     = scki_q;
   assign sdi      = sdi_sr_q[WORD_BITS-1];
   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign timeout  = timeout_q;
   assign overflow = overflow_q;

endmodule
`default_nettype wire
